// File: rtl/term_index_encoder.sv
// term_index_encoder
//
// Purpose:
//   Takes a completed term mask (one bit per power-of-two term) and serially
//   emits the index of each set bit, highest first, one index per accepted
//   beat. At most MAX_TERMS indices are emitted per mask; any bits left over
//   once that budget is spent are discarded. Sits between the mask register
//   and the per-term shift/accumulate datapath with valid/ready on both sides.
//
// Ports:
//   clk         in   1      single clock, rising edge
//   reset       in   1      synchronous, active-high
//   in_valid    in   1      in_mask valid
//   in_ready    out  1      block idle, can accept a mask
//   in_mask     in   WIDTH  term mask; bit i set = term 2^i present
//   out_valid   out  1      out_idx valid
//   out_ready   in   1      downstream accepts out_idx
//   out_idx     out  IDX_W  index of current highest remaining set bit
//   out_last    out  1      current beat is the final index for this mask
//   done        out  1      1-cycle pulse after the final beat or an empty mask
//   done_count  out  CNT_W  indices emitted for the mask; valid while done=1

module term_index_encoder #(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = 5,
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             done,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             done_q;
    logic             done_next;
    logic [CNT_W-1:0] done_cnt_q;
    logic [CNT_W-1:0] done_cnt_next;

    logic [IDX_W-1:0] hi_idx;
    logic             single_bit;
    logic             at_budget;
    logic             beat;

    // Priority encoder: scanning upward lets the highest set bit win.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask_q[i]) begin
                hi_idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when exactly one bit is
    // set; in EMIT the mask is never empty, so this is popcount==1.
    assign single_bit = ((mask_q & (mask_q - WIDTH'(1))) == '0);
    assign at_budget  = (cnt == CNT_W'(MAX_TERMS - 1));

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == EMIT);
    assign out_idx    = out_valid ? hi_idx : '0;
    assign out_last   = out_valid && (single_bit || at_budget);
    assign beat       = out_valid && out_ready;
    assign done       = done_q;
    assign done_count = done_q ? done_cnt_q : '0;

    // Next-state logic. The done pulse is registered so that it appears the
    // cycle after the final beat (or after an empty mask is accepted), which
    // is also the first cycle a new mask can be accepted.
    always_comb begin
        state_next    = state;
        mask_next     = mask_q;
        cnt_next      = cnt;
        done_next     = 1'b0;
        done_cnt_next = done_cnt_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mask_next = in_mask;
                    cnt_next  = '0;
                    if (in_mask != '0) begin
                        state_next = EMIT;
                    end else begin
                        done_next     = 1'b1;
                        done_cnt_next = '0;
                    end
                end
            end
            EMIT: begin
                if (beat) begin
                    mask_next = mask_q & ~(WIDTH'(1) << hi_idx);
                    cnt_next  = cnt + CNT_W'(1);
                    if (out_last) begin
                        state_next    = IDLE;
                        done_next     = 1'b1;
                        done_cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any mask in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mask_q     <= '0;
            cnt        <= '0;
            done_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state      <= state_next;
            mask_q     <= mask_next;
            cnt        <= cnt_next;
            done_q     <= done_next;
            done_cnt_q <= done_cnt_next;
        end
    end

endmodule

// File: tb/tb_term_index_encoder.sv
// tb_term_index_encoder
//
// Purpose:
//   Self-checking bench for term_index_encoder. Expected index sequences come
//   from a reference model that lists the set bits of a mask from the top down
//   and keeps the first MAX_TERMS of them. The DUT runs with a budget of 4 so
//   that budget truncation shows up on ordinary masks.
//
// Ports: none (top-level bench).

module tb_term_index_encoder;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;
    localparam int MT    = 4;
    localparam int CNT_W = 6;

    typedef int iq_t[$];

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             done;
    logic [CNT_W-1:0] done_count;

    int checks = 0;
    int errors = 0;

    term_index_encoder #(
        .WIDTH(WIDTH), .IDX_W(IDX_W), .MAX_TERMS(MT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .done(done), .done_count(done_count)
    );

    // Free-running clock; inputs are driven and outputs sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: set bits from the top down, truncated to the budget.
    function automatic iq_t model(input logic [WIDTH-1:0] m);
        iq_t q;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (m[b] && q.size() < MT) q.push_back(b);
        end
        return q;
    endfunction

    // Accept one mask, drain it with optional stalls and check the done pulse.
    task automatic run_mask(input logic [WIDTH-1:0] mask, input int first_stall, input bit rnd);
        iq_t exp;
        int  stall;
        exp = model(mask);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL accept_ready: got %0b expected 1", in_ready); end
        in_valid = 1'b1;
        in_mask  = mask;
        @(negedge clk);
        in_valid = 1'b0;
        in_mask  = $urandom;
        foreach (exp[i]) begin
            stall = (i == 0) ? first_stall : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid: got %0b expected 1", out_valid); end
                checks++; if (out_idx !== IDX_W'(exp[i])) begin errors++; $display("[TB] FAIL stall_idx: got %0d expected %0d", out_idx, exp[i]); end
                checks++; if (out_last !== (i == exp.size() - 1)) begin errors++; $display("[TB] FAIL stall_last: got %0b expected %0b", out_last, (i == exp.size() - 1)); end
                @(negedge clk);
            end
            out_ready = 1'b1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL beat_valid: got %0b expected 1", out_valid); end
            checks++; if (out_idx !== IDX_W'(exp[i])) begin errors++; $display("[TB] FAIL beat_idx: got %0d expected %0d (mask %h)", out_idx, exp[i], mask); end
            checks++; if (out_last !== (i == exp.size() - 1)) begin errors++; $display("[TB] FAIL beat_last: got %0b expected %0b (mask %h)", out_last, (i == exp.size() - 1), mask); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready: got %0b expected 0", in_ready); end
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL busy_done: got %0b expected 0", done); end
            @(negedge clk);
        end
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_pulse: got %0b expected 1 (mask %h)", done, mask); end
        checks++; if (done_count !== CNT_W'(exp.size())) begin errors++; $display("[TB] FAIL done_count: got %0d expected %0d (mask %h)", done_count, exp.size(), mask); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL done_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %0b expected 0", out_valid); end
        checks++; if (out_idx !== '0) begin errors++; $display("[TB] FAIL idle_idx: got %0d expected 0", out_idx); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_width: got %0b expected 0", done); end
    endtask

    // Reset dominates a simultaneous in_valid.
    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_idx !== '0) begin errors++; $display("[TB] FAIL reset_out_idx: got %0d expected 0", out_idx); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %0b expected 0", out_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (done_count !== '0) begin errors++; $display("[TB] FAIL reset_done_count: got %0d expected 0", done_count); end
        reset    = 1'b0;
        in_valid = 1'b0;
        in_mask  = '0;
        @(negedge clk);
    endtask

    task automatic test_two_terms();
        run_mask(32'h8000_0001, 0, 1'b0);
    endtask

    task automatic test_budget();
        run_mask(32'hFFFF_FFFF, 0, 1'b0);
        run_mask(32'h0000_001F, 0, 1'b0);
    endtask

    task automatic test_empty();
        run_mask(32'h0000_0000, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_mask(32'h0000_0104, 3, 1'b0);
    endtask

    // Reset after the first beat abandons the mask with no done pulse.
    task automatic test_reset_mid_emit();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 32'h0000_00F0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_idx !== 5'd7) begin errors++; $display("[TB] FAIL rst_first_idx: got %0d expected 7", out_idx); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %0b expected 1", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done: got %0b expected 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_after: got done=%0b valid=%0b expected 0/0", done, out_valid); end
    endtask

    // A second mask held during EMIT is taken in the done cycle of the first.
    task automatic test_back_to_back();
        iq_t ea;
        iq_t eb;
        ea = model(32'h0000_0030);
        eb = model(32'h8000_0001);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 32'h0000_0030;
        @(negedge clk);
        in_mask = 32'h8000_0001;
        foreach (ea[i]) begin
            checks++; if (out_idx !== IDX_W'(ea[i]) || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_a_idx: got %0d/%0b expected %0d/1", out_idx, out_valid, ea[i]); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_hold_ready: got %0b expected 0", in_ready); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || done_count !== CNT_W'(ea.size())) begin errors++; $display("[TB] FAIL b2b_a_done: got %0b/%0d expected 1/%0d", done, done_count, ea.size()); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_ready: got %0b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        foreach (eb[i]) begin
            checks++; if (out_idx !== IDX_W'(eb[i]) || out_last !== (i == eb.size() - 1)) begin errors++; $display("[TB] FAIL b2b_b_beat: got %0d/%0b expected %0d/%0b", out_idx, out_last, eb[i], (i == eb.size() - 1)); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || done_count !== CNT_W'(eb.size())) begin errors++; $display("[TB] FAIL b2b_b_done: got %0b/%0d expected 1/%0d", done, done_count, eb.size()); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] m;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       m = '0;
                1:       m = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                2:       m = $urandom & $urandom & $urandom;
                default: m = $urandom;
            endcase
            run_mask(m, 0, 1'b1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_two_terms();
        test_budget();
        test_empty();
        test_backpressure();
        test_reset_mid_emit();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
